// File: rtl/servo_pkg.sv
// Shared definitions for the servo slew limiter and its frame timer.
//   - Default timing constants (100 MHz clock, 20 ms frame, 1..2 ms pulse).
//   - Slew state encoding.
//   - clamp(): saturates a value into [lo, hi]; operates on CLAMP_W bits so
//     callers of any width up to CLAMP_W can share it.
package servo_pkg;

  localparam int unsigned DEF_FRAME_CYCLES = 2000000;
  localparam int unsigned DEF_STEP         = 1000;
  localparam int unsigned DEF_MIN_PW       = 100000;
  localparam int unsigned DEF_MAX_PW       = 200000;
  localparam int unsigned DEF_INIT_PW      = 150000;
  localparam int unsigned CLAMP_W          = 32;

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_TRACKING = 2'd1,
    S_SETTLED  = 2'd2
  } slew_state_t;

  function automatic logic [CLAMP_W-1:0] clamp(
    input logic [CLAMP_W-1:0] value,
    input logic [CLAMP_W-1:0] lo,
    input logic [CLAMP_W-1:0] hi
  );
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Free-running frame timer with enable.
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   en     : count enable; while low the count is held at 0 and tick is 0
//   tick   : one-cycle pulse in the cycle after the count reaches CYCLES-1,
//            so the first tick arrives CYCLES cycles after en rises
module frame_timer
  import servo_pkg::*;
#(
  parameter int unsigned CYCLES = DEF_FRAME_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  if (CYCLES < 1) begin : g_bad_cycles
    $error("frame_timer: CYCLES must be at least 1");
  end

  logic [CNT_W-1:0] count;
  logic             tick_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      tick_q <= 1'b0;
    end else if (!en) begin
      count  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (count == LAST);
      count  <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  // Gating with en means a frame boundary that coincides with en falling
  // is dropped rather than acted on by downstream logic.
  assign tick = tick_q & en;

endmodule

// File: rtl/servo_slew_limiter.sv
// Servo slew limiter: one instance per joint, between inverse kinematics and
// the PWM generator. Targets are clamped to [MIN_PW, MAX_PW] on capture; once
// per frame the commanded pulse width moves toward the latched target by at
// most STEP clock cycles.
//   clk          : system clock
//   reset        : asynchronous, active-low reset (snaps output to INIT_PW)
//   en           : motion enable; low freezes pulse_width and the frame timer
//   target       : requested pulse width in clock cycles
//   target_valid : one-cycle capture strobe for target
//   pulse_width  : slew-limited pulse width to the PWM
//   frame_tick   : one-cycle pulse at each frame boundary while enabled
//   settled      : registered, high when pulse_width equals the latched target
module servo_slew_limiter
  import servo_pkg::*;
#(
  parameter int unsigned WIDTH        = 24,
  parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int unsigned STEP         = DEF_STEP,
  parameter int unsigned MIN_PW       = DEF_MIN_PW,
  parameter int unsigned MAX_PW       = DEF_MAX_PW,
  parameter int unsigned INIT_PW      = DEF_INIT_PW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] target,
  input  logic             target_valid,
  output logic [WIDTH-1:0] pulse_width,
  output logic             frame_tick,
  output logic             settled
);

  if (STEP < 1) begin : g_bad_step
    $error("servo_slew_limiter: STEP must be at least 1");
  end
  if (MIN_PW > INIT_PW || INIT_PW > MAX_PW) begin : g_bad_init
    $error("servo_slew_limiter: INIT_PW must lie within [MIN_PW, MAX_PW]");
  end
  if (longint'(MAX_PW) >= (longint'(1) << WIDTH)) begin : g_bad_max
    $error("servo_slew_limiter: MAX_PW must fit in WIDTH bits");
  end
  if (WIDTH > CLAMP_W) begin : g_bad_width
    $error("servo_slew_limiter: WIDTH exceeds clamp helper width");
  end

  localparam logic [WIDTH-1:0]        INIT_W = WIDTH'(INIT_PW);
  localparam logic [WIDTH-1:0]        STEP_W = WIDTH'(STEP);
  localparam logic signed [WIDTH:0]   STEP_S = (WIDTH+1)'(STEP);

  // One slew step: the difference is taken one bit wider and signed so a
  // target below the current position can never wrap to a large positive.
  function automatic logic [WIDTH-1:0] slew_step(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] goal
  );
    logic signed [WIDTH:0] diff;
    diff = $signed({1'b0, goal}) - $signed({1'b0, cur});
    if (diff > STEP_S)       return cur + STEP_W;
    else if (diff < -STEP_S) return cur - STEP_W;
    else                     return goal;
  endfunction

  slew_state_t      state_q, state_d;
  logic [WIDTH-1:0] pw_q, pw_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] tgt_clamped;
  logic             settled_q;
  logic             match_d;

  frame_timer #(
    .CYCLES (FRAME_CYCLES)
  ) u_frame_timer (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (frame_tick)
  );

  assign tgt_clamped = WIDTH'(clamp(CLAMP_W'(target), CLAMP_W'(MIN_PW), CLAMP_W'(MAX_PW)));

  // Next-state logic. The state is derived from the values being registered
  // this cycle, so a capture is reflected in state the very next cycle and
  // the following frame tick is never missed. A tick coincident with a
  // capture still steps toward the old target because pw_d uses tgt_q.
  always_comb begin
    tgt_d   = tgt_q;
    pw_d    = pw_q;
    state_d = state_q;

    if (target_valid) tgt_d = tgt_clamped;
    if (state_q == S_TRACKING && frame_tick) pw_d = slew_step(pw_q, tgt_q);

    match_d = (pw_d == tgt_d);

    case (state_q)
      S_DISABLED: if (en) state_d = match_d ? S_SETTLED : S_TRACKING;
      S_TRACKING: if (match_d) state_d = S_SETTLED;
      S_SETTLED:  if (!match_d) state_d = S_TRACKING;
      default:    state_d = S_DISABLED;
    endcase

    if (!en) state_d = S_DISABLED;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_DISABLED;
      pw_q      <= INIT_W;
      tgt_q     <= INIT_W;
      settled_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      pw_q      <= pw_d;
      tgt_q     <= tgt_d;
      settled_q <= match_d;
    end
  end

  assign pulse_width = pw_q;
  assign settled     = settled_q;

endmodule
